mult_div_unit: RTL and testbench

Multiply/divide unit for the P6 pipeline's EX stage, beside the ALU. It takes the same SrcA/SrcB operands, holds the architectural HI/LO registers, and models multi-cycle MULT/MULTU/DIV/DIVU latency. It exposes a Busy flag so the hazard unit can stall later HI/LO-dependent instructions. MFHI/MFLO are served by reading the HI/LO outputs; MTHI/MTLO write through this block.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_compute.sv | 59 +++++
 rtl/mult_div_unit.sv | 120 ++++++++++++
 tb/tb_mult_div_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, default latencies.
package mdu_pkg;

    // MDUControl encodings as driven by the instruction decoder
    localparam logic [3:0] MDU_MULT  = 4'b0000;
    localparam logic [3:0] MDU_MULTU = 4'b0001;
    localparam logic [3:0] MDU_DIV   = 4'b0010;
    localparam logic [3:0] MDU_DIVU  = 4'b0011;
    localparam logic [3:0] MDU_MTHI  = 4'b0100;
    localparam logic [3:0] MDU_MTLO  = 4'b0101;

    // Default number of cycles Busy stays high for each operation class
    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational arithmetic core: 64-bit products, quotient/remainder, divide-by-zero detection.
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  op,
    output logic [63:0] hilo,
    output logic        div_by_zero
);

    logic signed [63:0] a_sext;
    logic signed [63:0] b_sext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    // Evaluate every result in parallel and select by opcode
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path can infer a latch.
        hilo        = 64'd0;
        div_by_zero = 1'b0;

        a_sext = {{32{src_a[31]}}, src_a};
        b_sext = {{32{src_b[31]}}, src_b};
        prod_s = a_sext * b_sext;
        prod_u = {32'd0, src_a} * {32'd0, src_b};

        // A zero divisor is replaced by 1 so the dividers never produce X; the flag
        // tells the sequencer to discard the result.
        divisor = (src_b == 32'd0) ? 32'd1 : src_b;
        quot_u  = src_a / divisor;
        rem_u   = src_a % divisor;

        // The only signed overflow case has a fixed architectural answer
        if ((src_a == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
            quot_s = 32'sh8000_0000;
            rem_s  = 32'sd0;
        end else begin
            quot_s = $signed(src_a) / $signed(divisor);
            rem_s  = $signed(src_a) % $signed(divisor);
        end

        case (op)
            MDU_MULT:  hilo = prod_s;
            MDU_MULTU: hilo = prod_u;
            MDU_DIV:   hilo = {rem_s, quot_s};
            MDU_DIVU:  hilo = {rem_u, quot_u};
            default:   hilo = 64'd0;
        endcase

        div_by_zero = is_div_op(op) && (src_b == 32'd0);
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO register file with a multi-cycle latency model for multiply and divide.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUControl,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    logic [63:0] calc_hilo;
    logic        calc_dz;
    logic        start_mul;
    logic        start_div;
    logic        completing;
    logic        launch;

    mdu_compute u_compute (
        .src_a       (SrcA),
        .src_b       (SrcB),
        .op          (MDUControl),
        .hilo        (calc_hilo),
        .div_by_zero (calc_dz)
    );

    assign start_mul  = Start && is_mul_op(MDUControl);
    assign start_div  = Start && is_div_op(MDUControl);
    assign completing = (state_q == S_RUN) && (cnt_q == CNT_ONE);
    // A new op may launch from IDLE or on the very edge the previous one commits
    assign launch     = (start_mul || start_div) && ((state_q == S_IDLE) || completing);

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Next-state: countdown, commit of pending result, launch, and MTHI/MTLO writes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        case (state_q)
            S_IDLE: begin
                if (Start && (MDUControl == MDU_MTHI)) begin
                    hi_d = SrcA;
                end else if (Start && (MDUControl == MDU_MTLO)) begin
                    lo_d = SrcA;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (completing) begin
                    state_d = S_IDLE;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d   = S_RUN;
            cnt_d     = start_mul ? MULT_LOAD : DIV_LOAD;
            pend_hi_d = calc_hilo[63:32];
            pend_lo_d = calc_hilo[31:0];
            pend_dz_d = calc_dz;
        end
    end

    // State and architectural registers; reset clears everything including pending results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  MDUControl;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests_run    = 0;
    int tests_failed = 0;

    // Architectural HI/LO as the model believes them to be
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .MDUControl (MDUControl),
        .Start      (Start),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clk = ~clk;

    // Reference model: applies one op to m_hi/m_lo and returns the expected Busy length
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        int          ia, ib;
        longint      la, lb, lp;
        logic [63:0] p;
        logic [31:0] ua, ub, qm, rm;
        lat = 0;
        case (op)
            OP_MULT: begin
                ia = a; ib = b; la = ia; lb = ib; lp = la * lb; p = lp;
                m_hi = p[63:32]; m_lo = p[31:0]; lat = MULT_N;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; lat = MULT_N;
            end
            OP_DIV: begin
                lat = DIV_N;
                if (b != 32'd0) begin
                    ua = a[31] ? -a : a;
                    ub = b[31] ? -b : b;
                    qm = ua / ub;
                    rm = ua % ub;
                    m_lo = (a[31] ^ b[31]) ? -qm : qm;
                    m_hi = a[31] ? -rm : rm;
                end
            end
            OP_DIVU: begin
                lat = DIV_N;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op and count how many sampled cycles Busy stays high afterwards
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        @(negedge clk);
        SrcA = a; SrcB = b; MDUControl = op; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            SrcA = $urandom; SrcB = $urandom; MDUControl = 4'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; SrcA = '0; SrcB = '0; MDUControl = '0;
        #12;
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith();
        logic [3:0]  ops [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
                                 32'h80000000, 32'd7};
        logic [31:0] bs  [6] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            model_op(ops[i], as[i], bs[i], lat);
            run_op(ops[i], as[i], bs[i], bc);
            tests_run++;
            if (bc !== lat || HI !== m_hi || LO !== m_lo) begin
                tests_failed++;
                $display("FAIL arith[%0d] op=%h: busy=%0d hi=%h lo=%h, want busy=%0d hi=%h lo=%h",
                         i, ops[i], bc, HI, LO, lat, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_mt_divzero();
        logic [3:0]  ops [5] = '{OP_MTHI, OP_DIV, OP_DIVU, OP_MTLO, 4'b1010};
        logic [31:0] as  [5] = '{32'h12345678, 32'd99, 32'd5, 32'hA5A5A5A5, 32'hDEADBEEF};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            model_op(ops[i], as[i], bs[i], lat);
            run_op(ops[i], as[i], bs[i], bc);
            tests_run++;
            if (bc !== lat || HI !== m_hi || LO !== m_lo) begin
                tests_failed++;
                $display("FAIL mt_divzero[%0d] op=%h: busy=%0d hi=%h lo=%h, want busy=%0d hi=%h lo=%h",
                         i, ops[i], bc, HI, LO, lat, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        model_op(OP_DIV, 32'd1000, 32'hFFFFFFFD, lat);
        @(negedge clk);
        SrcA = 32'd1000; SrcB = 32'hFFFFFFFD; MDUControl = OP_DIV; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        bc = 0;
        while (Busy === 1'b1 && bc < 100) begin
            bc++;
            SrcA = $urandom; SrcB = $urandom;
            if (bc == 3) begin
                Start = 1'b1; MDUControl = OP_MULT;
            end else if (bc == 4) begin
                Start = 1'b1; MDUControl = OP_MTHI;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        tests_run++;
        if (bc !== lat || HI !== m_hi || LO !== m_lo) begin
            tests_failed++;
            $display("FAIL ignore_start: busy=%0d hi=%h lo=%h, want busy=%0d hi=%h lo=%h",
                     bc, HI, LO, lat, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        logic [31:0] mid_hi, mid_lo;
        // MULT followed by a DIV launched in the cycle Busy falls
        model_op(OP_MULT, 32'hFFFF0003, 32'h00012345, lat1);
        mid_hi = m_hi; mid_lo = m_lo;
        model_op(OP_DIVU, 32'hF0000001, 32'd13, lat2);
        @(negedge clk);
        SrcA = 32'hFFFF0003; SrcB = 32'h00012345; MDUControl = OP_MULT; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        bc = 0;
        while (Busy === 1'b1 && bc < 100) begin
            bc++;
            if (bc == lat1) begin
                SrcA = 32'hF0000001; SrcB = 32'd13; MDUControl = OP_DIVU; Start = 1'b1;
            end else begin
                Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
            end
            @(negedge clk);
            if (bc == lat1) begin
                tests_run++;
                if (HI !== mid_hi || LO !== mid_lo || Busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_commit: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                             Busy, HI, LO, mid_hi, mid_lo);
                end
            end
        end
        Start = 1'b0;
        tests_run++;
        if (bc !== lat1 + lat2 || HI !== m_hi || LO !== m_lo) begin
            tests_failed++;
            $display("FAIL b2b_final: busy=%0d hi=%h lo=%h, want busy=%0d hi=%h lo=%h",
                     bc, HI, LO, lat1 + lat2, m_hi, m_lo);
        end

        // MTHI in the completing cycle is dropped
        model_op(OP_MULTU, 32'd3, 32'd4, lat1);
        @(negedge clk);
        SrcA = 32'd3; SrcB = 32'd4; MDUControl = OP_MULTU; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        bc = 0;
        while (Busy === 1'b1 && bc < 100) begin
            bc++;
            if (bc == lat1) begin
                SrcA = 32'hDEADBEEF; MDUControl = OP_MTHI; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bc !== lat1 || HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mt_on_fall: busy_cycles=%0d busy=%b hi=%h lo=%h, want %0d 0 hi=%h lo=%h",
                     bc, Busy, HI, LO, lat1, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            model_op(op, a, b, lat);
            run_op(op, a, b, bc);
            tests_run++;
            if (bc !== lat || HI !== m_hi || LO !== m_lo) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: busy=%0d hi=%h lo=%h, want busy=%0d hi=%h lo=%h",
                         i, op, a, b, bc, HI, LO, lat, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_midop();
        int bad;
        @(negedge clk);
        SrcA = 32'd12345; SrcB = 32'd17; MDUControl = OP_DIV; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", Busy, HI, LO);
        end
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < DIV_N + 5; i++) begin
            @(negedge clk);
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL reset_discard: %0d cycles with busy/hi/lo nonzero, want 0 (busy=%b hi=%h lo=%h)",
                     bad, Busy, HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mt_divzero();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
